// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Constants shared by the score keeper and the game-state block:
//                game-state codes, default win threshold, score-keeper FSM
//                encodings and a saturating score increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   // Game-state codes reported by the win-detection block
   localparam logic [1:0] GS_RESET  = 2'b00;
   localparam logic [1:0] GS_PLAY   = 2'b01;
   localparam logic [1:0] GS_P1_WIN = 2'b10;
   localparam logic [1:0] GS_P2_WIN = 2'b11;

   // Default goals-to-win; the game-state block must use the same threshold
   localparam logic [3:0] WIN_SCORE_DFLT = 4'd9;

   // Score-keeper rally sequencer states
   localparam logic [1:0] ST_SERVE = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_OVER  = 2'd2;

   // Both win codes have the MSB set; 00/01 never end the match
   function automatic logic is_win(input logic [1:0] gs);
      return gs[1];
   endfunction

   // Increment a score but hold it at the limit
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? v : v + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_keeper_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Two-flop sampling stage on a level input with a one-cycle
//                rising-edge strobe (rise = q1 & ~q2).
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic q1_q, q1_d;
   logic q2_q, q2_d;

   // Next values of the sampling chain
   always_comb begin
      q1_d = din;
      q2_d = q1_q;
   end

   // Sampling chain registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         q1_q <= 1'b0;
         q2_q <= 1'b0;
      end else begin
         q1_q <= q1_d;
         q2_q <= q2_d;
      end
   end

   assign rise = q1_q & ~q2_q;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Converts wall-hit goal levels into saturating P1/P2 scores,
//                holds the ball for a serve delay after each goal or new game,
//                chooses the serve side and freezes scoring once a win is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
   import pong_pkg::*;
#(
   parameter logic [3:0] WIN_SCORE      = WIN_SCORE_DFLT,
   parameter int         SERVE_DELAY_MS = 1000,
   parameter int         DLY_W          = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_1ms,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       new_game,
   input  logic [1:0] game_state,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic       ball_hold,
   output logic       serve_dir,
   output logic       goal_pulse
);

   localparam logic [DLY_W-1:0] CNT_LAST = DLY_W'(SERVE_DELAY_MS - 1);

   logic             rise_p1, rise_p2, rise_ms, rise_ng;

   logic [1:0]       state_q, state_d;
   logic [DLY_W-1:0] cnt_q,   cnt_d;
   logic [3:0]       p1_q,    p1_d;
   logic [3:0]       p2_q,    p2_d;
   logic             hold_q,  hold_d;
   logic             dir_q,   dir_d;
   logic             pulse_q, pulse_d;

   rise_detect u_rise_p1 (.clk(clk), .reset(reset), .din(goal_p1),  .rise(rise_p1));
   rise_detect u_rise_p2 (.clk(clk), .reset(reset), .din(goal_p2),  .rise(rise_p2));
   rise_detect u_rise_ms (.clk(clk), .reset(reset), .din(clk_1ms),  .rise(rise_ms));
   rise_detect u_rise_ng (.clk(clk), .reset(reset), .din(new_game), .rise(rise_ng));

   // Rally sequencer: win override first, then serve delay, goal scoring and restart
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      dir_d   = dir_q;
      pulse_d = 1'b0;

      if (is_win(game_state)) begin
         state_d = ST_OVER;
      end else begin
         case (state_q)
            ST_SERVE: begin
               if (rise_ms) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = ST_PLAY;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + DLY_W'(1);
                  end
               end
            end
            ST_PLAY: begin
               // Simultaneous hits on both walls are treated as no goal
               if (rise_p1 ^ rise_p2) begin
                  state_d = ST_SERVE;
                  cnt_d   = '0;
                  if (rise_p1) begin
                     p1_d    = sat_inc(p1_q, WIN_SCORE);
                     pulse_d = (p1_q < WIN_SCORE);
                     dir_d   = 1'b1;
                  end else begin
                     p2_d    = sat_inc(p2_q, WIN_SCORE);
                     pulse_d = (p2_q < WIN_SCORE);
                     dir_d   = 1'b0;
                  end
               end
            end
            ST_OVER: begin
               if (rise_ng) begin
                  state_d = ST_SERVE;
                  cnt_d   = '0;
                  p1_d    = 4'd0;
                  p2_d    = 4'd0;
                  dir_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_SERVE;
               cnt_d   = '0;
            end
         endcase
      end

      // Ball moves only while playing; registered so no input reaches it directly
      hold_d = (state_d != ST_PLAY);
   end

   // State, counter, score and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SERVE;
         cnt_q   <= '0;
         p1_q    <= 4'd0;
         p2_q    <= 4'd0;
         hold_q  <= 1'b1;
         dir_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         hold_q  <= hold_d;
         dir_q   <= dir_d;
         pulse_q <= pulse_d;
      end
   end

   assign p1_score   = p1_q;
   assign p2_score   = p2_q;
   assign ball_hold  = hold_q;
   assign serve_dir  = dir_q;
   assign goal_pulse = pulse_q;

endmodule
`default_nettype wire
